me_result_unloader: RTL and testbench
=====================================

// Module: me_result_unloader
// PURPOSE
// Consumer side of the me_top result interface (z / num_out / done). Captures one
// M_SIZE-bit modular-exponentiation/multiplication result with its request tag when
// done pulses, then streams it out LSB-first as OUT_W-bit beats over valid/ready.
// Sits between me_top and the host/DMA read path; frees me_top to start the next job.
// PARAMETERS
// M_SIZE   3072  result width in bits; must be an exact multiple of OUT_W
// OUT_W    64    output beat width in bits
// TAG_W    4     request tag width (matches me_top num/num_out)
// BEATS    M_SIZE/OUT_W (localparam, 48 at defaults) beats per result
// CNT_W    $clog2(BEATS) (localparam, 6 at defaults) beat counter width
// PORTS
// clk           in   1        system clock, all logic on rising edge
// rst_n         in   1        asynchronous active-low reset
// z             in   M_SIZE   result from me_top, valid only in the done cycle
// num_out       in   TAG_W    tag from me_top, valid only in the done cycle
// done          in   1        one-cycle pulse: z/num_out valid
// out_data      out  OUT_W    current beat, z[OUT_W*k +: OUT_W] for beat k
// out_tag       out  TAG_W    tag of the result being streamed, constant per result
// out_valid     out  1        beat available
// out_last      out  1        high with out_valid on beat BEATS-1
// out_ready     in   1        downstream accepts beat when out_valid && out_ready
// busy          out  1        result held (state STREAM)
// overflow      out  1        sticky: a done was dropped
// clr_overflow  in   1        synchronous clear of overflow
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, beat=0, out_valid=0, out_last=0,
//   busy=0, overflow=0, out_data=0, out_tag=0, capture register cleared.
// - States: IDLE (empty) and STREAM (holding result).
// - IDLE & done -> latch z and num_out, beat=0, go STREAM. done at edge N gives
//   out_valid=1 with beat 0 after edge N (visible in cycle N+1); 1-cycle latency.
// - STREAM: out_valid=1 continuously; out_data/out_tag/out_last stable while
//   out_valid && !out_ready. Handshake advances beat by 1 (shift-register or index mux).
// - out_last = out_valid && (beat == BEATS-1).
// - Handshake on last beat: done in same cycle -> capture new result, stay STREAM,
//   beat=0 (back-to-back, no bubble); else -> IDLE, out_valid=0 next cycle.
// - done in STREAM other than the last-beat handshake cycle: new result dropped, held
//   result unaffected, overflow set to 1.
// - clr_overflow clears overflow; same-cycle set and clear -> set wins.
// - out_ready ignored while out_valid=0; done with all-zero z is a normal result.
// - Reset mid-stream abandons the result; no partial beats after reset release.
// - Minimum throughput: one result per BEATS cycles with out_ready tied high.
// STRUCTURE
// - Shared package me_pkg: M_SIZE, TAG_W, OUT_W defaults, shared with me_top.
// - Single module; no sub-module. State, beat counter, M_SIZE capture/shift register,
//   tag register, sticky overflow flop.
// - Elaboration check: M_SIZE % OUT_W != 0 -> $error.
// TESTING
// 1 Basic: z with beat k = 64'h0000_0000_0000_00kk, num_out=3, out_ready=1 -> 48 beats
//   k=0..47 in order, out_tag=3 every beat, out_last only on beat 47, then out_valid=0.
// 2 Backpressure: out_ready random 30% duty -> same 48 beats, no loss/duplication,
//   out_data stable across every stalled cycle.
// 3 Back-to-back: second done (tag 4) on last-beat handshake of tag 3 -> 96 contiguous
//   beats, tag switches 3->4 at beat 48, overflow stays 0.
// 4 Overflow: done (tag 5) at beat 10 of tag 3 -> tag 3 completes intact, tag 5 never
//   appears, overflow=1; clr_overflow pulse -> 0; clr with concurrent drop -> stays 1.
// 5 Reset mid-op: rst_n low at beat 20 -> all outputs 0 immediately; after release,
//   new done (tag 6) streams from beat 0 correctly.
// 6 Latency: done at cycle N -> out_valid first high at N+1 with beat 0, tag as latched.

Source files
------------

// File: rtl/me_result_unloader_pkg.sv
// Shared defaults and types for the me_top result unloader.
//   ME_M_SIZE / ME_OUT_W / ME_TAG_W : default result, beat and tag widths
//   unl_state_e                     : unloader FSM state encoding
//   me_beats()                      : beats needed to stream one result
package me_result_unloader_pkg;

  localparam int unsigned ME_M_SIZE = 3072;
  localparam int unsigned ME_OUT_W  = 64;
  localparam int unsigned ME_TAG_W  = 4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } unl_state_e;

  function automatic int unsigned me_beats(input int unsigned m_size,
                                           input int unsigned out_w);
    return m_size / out_w;
  endfunction

endpackage

// File: rtl/me_result_unloader_if.sv
// Beat stream from the result unloader to the host/DMA read path.
//   out_data  : current beat, LSB-first slice of the held result
//   out_tag   : request tag of the result being streamed
//   out_valid : beat available
//   out_last  : final beat of the result
//   out_ready : consumer accepts the beat when out_valid && out_ready
// master = unloader side, slave = consumer side.
interface me_result_unloader_if #(
  parameter int unsigned OUT_W = 64,
  parameter int unsigned TAG_W = 4
);

  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output out_data,
    output out_tag,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_tag,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/me_result_unloader.sv
// Consumer of the me_top result interface. Captures one M_SIZE-bit result and
// its tag on the done pulse, then streams it LSB-first as OUT_W-bit beats.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   z, num_out    : result and tag from me_top, valid in the done cycle
//   done          : one-cycle capture strobe
//   out_if        : beat stream (master side)
//   busy          : a result is held
//   overflow      : sticky, a done arrived while busy and was dropped
//   clr_overflow  : synchronous clear of overflow (a same-cycle drop wins)
module me_result_unloader
  import me_result_unloader_pkg::*;
#(
  parameter int unsigned M_SIZE = ME_M_SIZE,
  parameter int unsigned OUT_W  = ME_OUT_W,
  parameter int unsigned TAG_W  = ME_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [M_SIZE-1:0]    z,
  input  logic [TAG_W-1:0]     num_out,
  input  logic                 done,
  me_result_unloader_if.master out_if,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 clr_overflow
);

  localparam int unsigned BEATS = me_beats(M_SIZE, OUT_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Beat index after which the next beat is the last one.
  localparam logic [CNT_W-1:0] PENULT = CNT_W'((BEATS >= 2) ? BEATS - 2 : 0);

  if (M_SIZE % OUT_W != 0) begin : g_bad_size
    $error("me_result_unloader: M_SIZE must be a multiple of OUT_W");
  end

  unl_state_e        state_q;
  logic [CNT_W-1:0]  beat_q;
  logic [M_SIZE-1:0] cap_q;
  logic [TAG_W-1:0]  tag_q;
  logic              last_q;
  logic              ovf_q;

  logic handshake;
  logic last_hs;
  logic drop;

  assign handshake = (state_q == ST_STREAM) && out_if.out_ready;
  assign last_hs   = handshake && last_q;
  // Only the last-beat handshake can absorb a new done; any other done while
  // busy is lost.
  assign drop      = (state_q == ST_STREAM) && done && !last_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      cap_q   <= '0;
      tag_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow) begin
        ovf_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (done) begin
            cap_q   <= z;
            tag_q   <= num_out;
            beat_q  <= '0;
            last_q  <= (BEATS == 1);
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (last_hs) begin
            if (done) begin
              cap_q  <= z;
              tag_q  <= num_out;
              beat_q <= '0;
              last_q <= (BEATS == 1);
            end else begin
              cap_q   <= '0;
              beat_q  <= '0;
              last_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (handshake) begin
            // Shift register: the low OUT_W bits always hold the current beat.
            cap_q  <= cap_q >> OUT_W;
            beat_q <= beat_q + CNT_W'(1);
            last_q <= (beat_q == PENULT);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_if.out_data  = cap_q[OUT_W-1:0];
  assign out_if.out_tag   = tag_q;
  assign out_if.out_valid = (state_q == ST_STREAM);
  assign out_if.out_last  = last_q;
  assign busy             = (state_q == ST_STREAM);
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_me_result_unloader.sv
module tb_me_result_unloader;

  localparam int unsigned M_SIZE = 3072;
  localparam int unsigned OUT_W  = 64;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned BEATS  = M_SIZE / OUT_W;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [TAG_W-1:0] t;
    logic             l;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [M_SIZE-1:0] z;
  logic [TAG_W-1:0]  num_out;
  logic              done;
  logic              busy;
  logic              overflow;
  logic              clr_overflow;

  me_result_unloader_if #(.OUT_W(OUT_W), .TAG_W(TAG_W)) sif ();

  me_result_unloader #(
    .M_SIZE(M_SIZE),
    .OUT_W (OUT_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .z           (z),
    .num_out     (num_out),
    .done        (done),
    .out_if      (sif.master),
    .busy        (busy),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every handshake and checks hold during stalls.
  logic             stall_pend = 1'b0;
  logic [OUT_W-1:0] held_d;
  logic [TAG_W-1:0] held_t;
  logic             held_l;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", {127'b0, sif.out_valid}, 128'd1);
        chk("stall_data", {64'b0, sif.out_data}, {64'b0, held_d});
        chk("stall_tag_last", {123'b0, sif.out_tag, sif.out_last}, {123'b0, held_t, held_l});
      end
      stall_pend = sif.out_valid && !sif.out_ready;
      held_d = sif.out_data;
      held_t = sif.out_tag;
      held_l = sif.out_last;
      if (sif.out_valid && sif.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h tag %0h, expected no beat",
                   sif.out_data, sif.out_tag);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_data", {64'b0, sif.out_data}, {64'b0, e.d});
          chk("beat_tag", {124'b0, sif.out_tag}, {124'b0, e.t});
          chk("beat_last", {127'b0, sif.out_last}, {127'b0, e.l});
        end
      end
    end
  end

  function automatic logic [M_SIZE-1:0] build_z(input logic [OUT_W-1:0] base);
    logic [M_SIZE-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < BEATS; k++) r[OUT_W*k +: OUT_W] = base + OUT_W'(k);
    return r;
  endfunction

  task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] base);
    for (int unsigned k = 0; k < BEATS; k++) begin
      beat_t e;
      e.d = base + OUT_W'(k);
      e.t = tag;
      e.l = (k == BEATS - 1);
      sb.push_back(e);
    end
  endtask

  // Drive done now (just after an edge); sampled at the next edge.
  task automatic pulse_now(input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] base);
    z       = build_z(base);
    num_out = tag;
    done    = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
  endtask

  task automatic pulse_done(input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] base);
    @(posedge clk);
    #1 pulse_now(tag, base);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(name, {96'b0, sb.size()}, 128'd0);
    if (sb.size() != 0) sb.delete();
    @(negedge clk);
    chk({name, "_idle"}, {127'b0, sif.out_valid}, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    z             = '0;
    num_out       = '0;
    done          = 1'b0;
    clr_overflow  = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {127'b0, sif.out_valid}, 128'd0);
    chk("rst_busy_ovf_last", {125'b0, busy, overflow, sif.out_last}, 128'd0);
    chk("rst_data_tag", {60'b0, sif.out_data, sif.out_tag}, 128'd0);
    rst_n = 1'b1;

    // 1 + 6: basic stream with latency check
    sif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    push_exp(4'd3, 64'd0);
    z = build_z(64'd0); num_out = 4'd3; done = 1'b1;
    @(negedge clk);
    chk("lat_before", {127'b0, sif.out_valid}, 128'd0);
    @(posedge clk);
    #1 done = 1'b0;
    @(negedge clk);
    chk("lat_valid", {127'b0, sif.out_valid}, 128'd1);
    chk("lat_tag", {124'b0, sif.out_tag}, 128'd3);
    chk("lat_busy", {127'b0, busy}, 128'd1);
    wait_drain("basic_drain", 200);

    // 2: backpressure with ~30% ready duty
    sif.out_ready = 1'b0;
    push_exp(4'd3, 64'h1000);
    pulse_done(4'd3, 64'h1000);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1 sif.out_ready = ($urandom_range(0, 9) < 3);
      if (sb.size() == 0) break;
    end
    wait_drain("bp_drain", 10);
    sif.out_ready = 1'b1;

    // 3: back-to-back, new done on the last-beat handshake
    push_exp(4'd3, 64'h2000);
    pulse_done(4'd3, 64'h2000);
    for (int i = 0; i < 200; i++) begin
      if (sif.out_last) break;
      @(posedge clk);
      #1;
    end
    chk("b2b_found_last", {127'b0, sif.out_last}, 128'd1);
    push_exp(4'd4, 64'h4000);
    pulse_now(4'd4, 64'h4000);
    @(negedge clk);
    chk("b2b_contig_valid", {127'b0, sif.out_valid}, 128'd1);
    chk("b2b_tag", {124'b0, sif.out_tag}, 128'd4);
    chk("b2b_ovf", {127'b0, overflow}, 128'd0);
    wait_drain("b2b_drain", 200);

    // 4: overflow on a mid-stream done, then clear behaviour
    push_exp(4'd3, 64'h3000);
    pulse_done(4'd3, 64'h3000);
    repeat (9) @(posedge clk);
    #1 pulse_now(4'd5, 64'h5000);
    @(negedge clk);
    chk("ovf_set", {127'b0, overflow}, 128'd1);
    wait_drain("ovf_drain", 200);
    chk("ovf_sticky", {127'b0, overflow}, 128'd1);
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    @(posedge clk);
    #1 clr_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_clr", {127'b0, overflow}, 128'd0);
    push_exp(4'd3, 64'h3100);
    pulse_done(4'd3, 64'h3100);
    repeat (5) @(posedge clk);
    #1 clr_overflow = 1'b1;
    pulse_now(4'd5, 64'h5100);
    clr_overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", {127'b0, overflow}, 128'd1);
    wait_drain("ovf2_drain", 200);
    @(posedge clk);
    #1 clr_overflow = 1'b1;
    @(posedge clk);
    #1 clr_overflow = 1'b0;

    // 5: reset mid-stream, then a fresh result
    push_exp(4'd3, 64'h6000);
    pulse_done(4'd3, 64'h6000);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_busy", {126'b0, sif.out_valid, busy}, 128'd0);
    chk("mid_rst_data_tag_last", {59'b0, sif.out_data, sif.out_tag, sif.out_last}, 128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {127'b0, sif.out_valid}, 128'd0);
    push_exp(4'd6, 64'h7000);
    pulse_done(4'd6, 64'h7000);
    wait_drain("post_rst_drain", 200);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
